// File: rtl/wb_tia_sequencer_pkg.sv
// Shared definitions for the TIA Wishbone command sequencer:
// command opcodes, TIA register addresses and FSM state encoding.
package wb_tia_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SYNC  = 2'b10;
  localparam logic [1:0] OP_DELAY = 2'b11;

  localparam logic [6:0] WSYNC  = 7'h02;
  localparam logic [6:0] COLUBK = 7'h09;
  localparam logic [6:0] INPT4  = 7'h0c;
  localparam logic [6:0] HMOVE  = 7'h2a;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STB,
    ST_WAIT_ACK,
    ST_SYNC,
    ST_DELAY,
    ST_RESP
  } state_e;

endpackage

// File: rtl/wb_tia_sequencer_sync_fifo.sv
// Single-clock FIFO with combinational head read and full/empty flags.
// Caller guarantees no pop when empty and no push when full unless popping.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_dat = mem[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/wb_tia_sequencer.sv
// Wishbone initiator replaying a queued command stream into the TIA register file,
// with single-cycle strobes, WSYNC stall handling, ack timeout and read responses.
module wb_tia_sequencer
  import wb_tia_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] cmd_dat_i,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                     rsp_err_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     stall_i,
  output logic                     busy_o
);

  localparam int CMD_W = 2 + WB_ADDR_WIDTH + WB_DATA_WIDTH;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CMD_W-1:0]         head;
  logic [1:0]               head_op;
  logic [WB_ADDR_WIDTH-1:0] head_adr;
  logic [WB_DATA_WIDTH-1:0] head_dat;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     load_bus;

  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [WB_DATA_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [WB_DATA_WIDTH-1:0] cap_dat_q, cap_dat_d;
  logic                     err_q, err_d;
  logic                     we_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [WB_DATA_WIDTH-1:0] dat_q;
  logic                     rsp_valid_q;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_q;
  logic                     rsp_err_q;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign cmd_ready_o = !fifo_full || pop;
  assign push        = cmd_valid_i && cmd_ready_o;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push),
    .push_dat ({cmd_op_i, cmd_adr_i, cmd_dat_i}),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_op, head_adr, head_dat} = head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_bus  = 1'b0;
    to_cnt_d  = to_cnt_q;
    dly_cnt_d = dly_cnt_q;
    cap_dat_d = cap_dat_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !stall_i) begin
          pop = 1'b1;
          case (head_op)
            OP_WRITE, OP_READ: begin
              load_bus = 1'b1;
              state_d  = ST_STB;
            end
            OP_SYNC: state_d = ST_SYNC;
            default: begin
              dly_cnt_d = head_dat;
              state_d   = ST_DELAY;
            end
          endcase
        end
      end
      ST_STB, ST_WAIT_ACK: begin
        // The strobe is never held: the TIA acts on a single strobe edge.
        if (ack_i) begin
          err_d     = 1'b0;
          cap_dat_d = dat_i;
          state_d   = we_q ? ST_IDLE : ST_RESP;
        end else if (state_q == ST_STB) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT_ACK;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_SYNC: begin
        if (!stall_i) state_d = ST_IDLE;
      end
      ST_DELAY: begin
        if (dly_cnt_q == '0) state_d = ST_IDLE;
        else                 dly_cnt_d = dly_cnt_q - WB_DATA_WIDTH'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q    <= '0;
      dly_cnt_q   <= '0;
      cap_dat_q   <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      cap_dat_q   <= cap_dat_d;
      err_q       <= err_d;
      rsp_valid_q <= (state_q == ST_RESP);
      if (load_bus) begin
        we_q  <= (head_op == OP_WRITE);
        adr_q <= head_adr;
        dat_q <= head_dat;
      end
      if (state_q == ST_RESP) begin
        rsp_dat_q <= err_q ? '0 : cap_dat_q;
        rsp_err_q <= err_q;
      end
    end
  end

  // Strobe decodes straight from state so reset drops it asynchronously.
  assign stb_o       = (state_q == ST_STB);
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

endmodule
